// File: rtl/fd_flush_pipe_reg_pkg.sv
// Shared constants and types for the fetch-to-decode pipeline register.
// Flush encodings, the NOP word and the queue occupancy states.
package fd_flush_pipe_reg_pkg;

    localparam logic        PLFLUSH_ENABLE  = 1'b1;
    localparam logic        PLFLUSH_DISABLE = 1'b0;
    localparam logic [31:0] NOP_ENCODING    = 32'h0000_0013;

    typedef enum logic [1:0] {
        FDQ_EMPTY = 2'd0,
        FDQ_ONE   = 2'd1,
        FDQ_FULL  = 2'd2
    } fdq_state_e;

    function automatic logic [1:0] fdq_count(input fdq_state_e s);
        case (s)
            FDQ_ONE:  return 2'd1;
            FDQ_FULL: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fd_flush_pipe_reg_if.sv
// Fetch/decode handshake bundle for the F->D pipeline register.
// Signal suffixes are relative to the buffer (slave) side.
interface fd_flush_pipe_reg_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);

    logic             pipeline_Flush_i;
    logic             f_valid_i;
    logic             f_ready_o;
    logic [XLEN-1:0]  f_pc_i;
    logic [31:0]      f_inst_i;
    logic             d_valid_o;
    logic             d_ready_i;
    logic [XLEN-1:0]  d_pc_o;
    logic [31:0]      d_inst_o;
    logic [CNT_W-1:0] squash_cnt_o;

    modport master (
        output pipeline_Flush_i, f_valid_i, f_pc_i, f_inst_i, d_ready_i,
        input  f_ready_o, d_valid_o, d_pc_o, d_inst_o, squash_cnt_o
    );

    modport slave (
        input  pipeline_Flush_i, f_valid_i, f_pc_i, f_inst_i, d_ready_i,
        output f_ready_o, d_valid_o, d_pc_o, d_inst_o, squash_cnt_o
    );

endinterface

// File: rtl/fd_flush_pipe_reg_sat_counter.sv
// Saturating event counter taking an increment of 0..3 per cycle.
// Reusable for hazard performance counters; async active-low clear.
module fd_flush_pipe_reg_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [1:0]       inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH+1:0] MAX_VAL = {2'b00, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH+1:0] w_sum;

    // Two guard bits so that a 2-bit increment cannot wrap before the compare.
    assign w_sum = {2'b00, r_cnt} + {{WIDTH{1'b0}}, inc_i};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (w_sum > MAX_VAL) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_sum[WIDTH-1:0];
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/fd_flush_pipe_reg.sv
// F->D pipeline register: 2-entry skid buffer with valid/ready on both sides.
// A flush squashes held and incoming beats and adds them to a saturating counter.
module fd_flush_pipe_reg
    import fd_flush_pipe_reg_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_INST = NOP_ENCODING
) (
    input logic                clk_i,
    input logic                rstn_i,
    fd_flush_pipe_reg_if.slave bus
);

    fdq_state_e      r_state;
    fdq_state_e      w_state_nxt;
    logic            r_head;
    logic            r_tail;
    logic [XLEN-1:0] r_pc   [2];
    logic [31:0]     r_inst [2];
    logic [XLEN-1:0] r_pc_hold;

    logic            w_flush;
    logic            w_ready;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_sq_inc;

    assign w_flush = (bus.pipeline_Flush_i == PLFLUSH_ENABLE);
    // Held low in reset; otherwise depends only on the registered occupancy.
    assign w_ready = rstn_i & (r_state != FDQ_FULL);
    assign w_valid = (r_state != FDQ_EMPTY) & (bus.pipeline_Flush_i == PLFLUSH_DISABLE);
    assign w_push  = bus.f_valid_i & w_ready;
    assign w_pop   = w_valid & bus.d_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_sq_inc    = 2'd0;
        if (w_flush) begin
            w_state_nxt = FDQ_EMPTY;
            w_sq_inc    = fdq_count(r_state) + {1'b0, w_push};
        end else begin
            unique case (r_state)
                FDQ_EMPTY: if (w_push) w_state_nxt = FDQ_ONE;
                FDQ_ONE: begin
                    if (w_push && !w_pop) begin
                        w_state_nxt = FDQ_FULL;
                    end else if (!w_push && w_pop) begin
                        w_state_nxt = FDQ_EMPTY;
                    end
                end
                FDQ_FULL:  if (w_pop) w_state_nxt = FDQ_ONE;
                default:   w_state_nxt = FDQ_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= FDQ_EMPTY;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_pc_hold <= '0;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_valid) begin
                r_pc_hold <= r_pc[r_head];
            end
            if (w_flush) begin
                r_head <= 1'b0;
                r_tail <= 1'b0;
            end else begin
                if (w_push) begin
                    r_pc[r_tail]   <= bus.f_pc_i;
                    r_inst[r_tail] <= bus.f_inst_i;
                    r_tail         <= ~r_tail;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

    fd_flush_pipe_reg_sat_counter #(
        .WIDTH (CNT_W)
    ) u_squash_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (w_sq_inc),
        .cnt_o  (bus.squash_cnt_o)
    );

    assign bus.f_ready_o = w_ready;
    assign bus.d_valid_o = w_valid;
    assign bus.d_pc_o    = w_valid ? r_pc[r_head] : r_pc_hold;
    assign bus.d_inst_o  = w_valid ? r_inst[r_head] : NOP_INST;

endmodule

// File: doc/fd_flush_pipe_reg.md
Name: fd_flush_pipe_reg

Overview:
- Fetch-to-decode (F->D) pipeline register group for the RV32 core.
- Consumes the `pipeline_Flush` signal raised when `PCSel` selects the ALU target (taken branch or jump).
- Implemented as a 2-entry skid buffer with a valid/ready handshake on both sides.
- On flush it squashes every wrong-path instruction it holds or is receiving, and counts them for performance monitoring.

Parameters:
- XLEN, 32, width of the PC field.
- CNT_W, 16, width of the saturating squash counter.
- NOP_INST, 32'h00000013, instruction word driven on `d_inst_o` when no valid entry exists (addi x0,x0,0).

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- pipeline_Flush_i  in  1  flush request; `PLFLUSH_ENABLE` = squash, `PLFLUSH_DISABLE` = normal.
- f_valid_i  in  1  fetch stage presents an instruction.
- f_ready_o  out  1  buffer can accept a beat this cycle.
- f_pc_i  in  XLEN  PC of the fetched instruction.
- f_inst_i  in  32  fetched instruction word.
- d_valid_o  out  1  decode stage has a valid instruction.
- d_ready_i  in  1  decode stage consumes the head this cycle.
- d_pc_o  out  XLEN  PC of the head entry.
- d_inst_o  out  32  instruction word of the head entry; NOP_INST when empty.
- squash_cnt_o  out  CNT_W  total valid instructions discarded by flushes; saturating.

Behaviour:
- Storage: two entries {pc, inst}, head/tail pointers, state EMPTY / ONE / FULL.
- Reset (async, rstn_i low):
  - state EMPTY, pointers 0, squash_cnt_o 0.
  - d_valid_o 0, d_pc_o 0, d_inst_o NOP_INST.
  - f_ready_o 0 while in reset, 1 on the first cycle after release.
- Handshakes:
  - push = f_valid_i & f_ready_o; pop = d_valid_o & d_ready_i.
  - f_ready_o is a function of registered state only (state != FULL); no combinational path from d_ready_i.
  - d_valid_o = (state != EMPTY) & (pipeline_Flush_i == `PLFLUSH_DISABLE`). Flush masks it in the same cycle, so decode never consumes a wrong-path head.
  - d_pc_o / d_inst_o come from the head entry; when not valid, d_inst_o = NOP_INST and d_pc_o holds its last value.
- Latency: a beat pushed into EMPTY appears on d_* on the next cycle (1-cycle latency).
- Transitions without flush:
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; !push & pop -> EMPTY; push & pop -> ONE.
  - FULL: pop -> ONE. No push is possible because f_ready_o = 0.
- Pointer rule: the tail advances on push and the head advances on pop, each mod 2. Wrap-around must preserve order across arbitrary push/pop interleaving.
- Flush cycle (pipeline_Flush_i == `PLFLUSH_ENABLE`):
  - At the next edge: state EMPTY, both pointers 0.
  - An incoming f_valid_i beat is accepted if f_ready_o and then discarded.
  - No pop occurs, since d_valid_o is masked.
  - squash_cnt_o += (entries held: 0/1/2) + (push ? 1 : 0). Increment of 0..3, saturating at all ones.
- Consecutive flush cycles: each cycle squashes independently. A beat pushed during flush is never stored.
- Flush with d_ready_i = 1: no pop, no count of that entry as consumed; it is counted as squashed.
- Reset mid-operation: entries lost and squash_cnt_o cleared immediately and asynchronously. No output glitches to valid.
- Counter saturation: once squash_cnt_o reaches 2^CNT_W-1 it holds that value until reset.

Decomposition:
- core_param.v (shared): `PLFLUSH_ENABLE`, `PLFLUSH_DISABLE`, NOP encoding constant, state encodings `FDQ_EMPTY` / `FDQ_ONE` / `FDQ_FULL`.
- One natural sub-module: `sat_counter` (parameterised width, increment input 0..3, saturate, async active-low clear). It is reusable for other hazard performance counters.
- Storage and pointers stay in the top module.

Test Plan:
- Reset then idle: rstn_i low 3 cycles, release -> d_valid_o 0, d_inst_o 32'h00000013, squash_cnt_o 0, f_ready_o 1 on the first post-reset cycle.
- Streaming: push pc 0x0,0x4,0x8 on consecutive cycles with d_ready_i 1 -> d_pc_o 0x0,0x4,0x8 each 1 cycle after push, state never FULL, squash_cnt_o 0.
- Back-pressure and wrap: d_ready_i 0, push 0x10,0x14 -> f_ready_o 0. Release d_ready_i, push 0x18 once ONE -> output order 0x10,0x14,0x18.
- Flush while FULL with incoming beat: FULL (0x20,0x24), f_valid_i 1, flush 1 cycle -> d_valid_o 0 that cycle, next cycle EMPTY, squash_cnt_o 2 (beat not accepted since FULL).
- Flush while ONE with accepted incoming beat and d_ready_i 1 -> no pop, squash_cnt_o += 2, next-cycle d_valid_o 0.
- Saturation and async reset: CNT_W=2, force 4 squashes -> squash_cnt_o holds 3. Drop rstn_i mid-cycle -> counter 0 and d_valid_o 0 before the next clock edge.
